// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, field decode, 32x32 register file with
// write-through bypass, and load-use hazard detection.
module id_stage #(
    parameter int PC_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] PCnext_in,
    input  logic [31:0]         Instruction_in,
    input  logic                flush,
    input  logic                ex_MemRead,
    input  logic [4:0]          ex_rt,
    input  logic                wb_RegWrite,
    input  logic [4:0]          wb_rd,
    input  logic [31:0]         wb_data,
    output logic [PC_WIDTH-1:0] PCnext_out,
    output logic                valid,
    output logic [5:0]          opcode,
    output logic [5:0]          funct,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [31:0]         imm_ext,
    output logic [31:0]         rs_data,
    output logic [31:0]         rt_data,
    output logic                stall
);

    logic [31:0]         ir_q;
    logic [31:0]         ir_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                valid_q;
    logic                valid_d;
    logic [31:0]         regs_q [32];
    logic                wb_en_s;
    logic                stall_s;

    // Register-field decode straight from the latched instruction.
    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};

    assign PCnext_out = pc_q;
    assign valid      = valid_q;
    assign stall      = stall_s;

    // Register 0 is hardwired, so a write aimed at it never enables.
    assign wb_en_s = wb_RegWrite & (wb_rd != 5'd0);

    // Load-use hazard: a bubble decodes to all-zero fields and never stalls.
    always_comb begin
        stall_s = 1'b0;
        if (valid_q && ex_MemRead && (ex_rt != 5'd0) &&
            ((ex_rt == ir_q[25:21]) || (ex_rt == ir_q[20:16]))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // IF/ID next-state: flush beats stall, stall beats load.
    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            ir_d    = 32'd0;
            valid_d = 1'b0;
        end else if (stall_s) begin
            ir_d    = ir_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end else begin
            ir_d    = Instruction_in;
            pc_d    = PCnext_in;
            valid_d = 1'b1;
        end
    end

    // IF/ID latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q    <= 32'd0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Register file storage; entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wb_en_s) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Operand read with same-cycle write-through from write-back.
    always_comb begin
        rs_data = 32'd0;
        rt_data = 32'd0;
        if (wb_en_s && (wb_rd == ir_q[25:21])) begin
            rs_data = wb_data;
        end else if (ir_q[25:21] != 5'd0) begin
            rs_data = regs_q[ir_q[25:21]];
        end else begin
            rs_data = 32'd0;
        end
        if (wb_en_s && (wb_rd == ir_q[20:16])) begin
            rt_data = wb_data;
        end else if (ir_q[20:16] != 5'd0) begin
            rt_data = regs_q[ir_q[20:16]];
        end else begin
            rt_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage checked every cycle against an array/variable
// model of the decode stage, plus literal scenario checks.
module tb_id_stage;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] PCnext_in;
    logic [31:0]   Instruction_in;
    logic          flush;
    logic          ex_MemRead;
    logic [4:0]    ex_rt;
    logic          wb_RegWrite;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic [PW-1:0] PCnext_out;
    logic          valid;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [31:0]   imm_ext;
    logic [31:0]   rs_data;
    logic [31:0]   rt_data;
    logic          stall;

    id_stage #(.PC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .PCnext_in(PCnext_in), .Instruction_in(Instruction_in),
        .flush(flush), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .PCnext_out(PCnext_out), .valid(valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0]   m_ir;
    logic [PW-1:0] m_pc;
    logic          m_valid;
    logic [31:0]   m_rf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ir = 32'd0; m_pc = '0; m_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic m_stall();
        logic [4:0] a, b;
        a = m_ir[25:21]; b = m_ir[20:16];
        return m_valid && ex_MemRead && ex_rt != 5'd0 && (ex_rt == a || ex_rt == b);
    endfunction

    task automatic compare_all();
        logic [15:0] lo;
        lo = m_ir[15:0];
        chk("pc", 32'(PCnext_out), 32'(m_pc));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("opcode", 32'(opcode), 32'(m_ir >> 26));
        chk("rs", 32'(rs), (m_ir >> 21) & 32'h1F);
        chk("rt", 32'(rt), (m_ir >> 16) & 32'h1F);
        chk("rd", 32'(rd), (m_ir >> 11) & 32'h1F);
        chk("funct", 32'(funct), m_ir & 32'h3F);
        chk("imm_ext", imm_ext, lo[15] ? (32'hFFFF0000 | 32'(lo)) : 32'(lo));
        chk("rs_data", rs_data, m_read(m_ir[25:21]));
        chk("rt_data", rt_data, m_read(m_ir[20:16]));
        chk("stall", 32'(stall), 32'(m_stall()));
    endtask

    task automatic drive(input logic fl, input logic ld, input logic [4:0] ert,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic [31:0] ins, input logic [PW-1:0] pc);
        flush = fl; ex_MemRead = ld; ex_rt = ert;
        wb_RegWrite = we; wb_rd = wrd; wb_data = wd;
        Instruction_in = ins; PCnext_in = pc;
    endtask

    // Check current outputs, then advance one edge and update the model.
    task automatic tick();
        logic st;
        #1;
        compare_all();
        st = m_stall();
        @(posedge clk);
        if (flush) begin
            m_ir = 32'd0; m_valid = 1'b0;
        end else if (!st) begin
            m_ir = Instruction_in; m_pc = PCnext_in; m_valid = 1'b1;
        end
        if (wb_RegWrite && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        #1;
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  ert;
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 6'd0);
        model_reset();
        #2;
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_pc", 32'(PCnext_out), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        compare_all();
        @(posedge clk); #1;
        rst = 1'b1;

        // Sign-extended addi decode
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'h2008FFFC, 6'd4);
        tick();
        chk("d_opcode", 32'(opcode), 32'h08);
        chk("d_rs", 32'(rs), 32'd0);
        chk("d_rt", 32'(rt), 32'd8);
        chk("d_imm", imm_ext, 32'hFFFFFFFC);
        chk("d_pc", 32'(PCnext_out), 32'd4);
        chk("d_valid", 32'(valid), 32'd1);

        // Bypass then stored read of r9
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'h01200000, 6'd8);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h12345678, 32'h01200000, 6'd8);
        #1 chk("bypass_rs", rs_data, 32'h12345678);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 32'h0, 32'h01200000, 6'd8);
        #1 chk("stored_rs", rs_data, 32'h12345678);
        tick();

        // Writes to r0 are discarded
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h00000000, 6'd12);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'h00000000, 6'd12);
        #1 chk("r0_zero", rs_data, 32'd0);
        tick();

        // Load-use stall holds the latch for one edge
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'h00A00000, 6'd8);
        tick();
        drive(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 32'h00C00000, 6'd12);
        #1 chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_hold_rs", 32'(rs), 32'd5);
        chk("lu_hold_pc", 32'(PCnext_out), 32'd8);
        drive(1'b0, 1'b0, 5'd5, 1'b0, 5'd0, 32'd0, 32'h00C00000, 6'd12);
        #1 chk("lu_release", 32'(stall), 32'd0);
        tick();
        chk("lu_new_rs", 32'(rs), 32'd6);
        chk("lu_new_pc", 32'(PCnext_out), 32'd12);

        // Flush wins over stall
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'h00A00000, 6'd16);
        tick();
        drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 32'h00C00000, 6'd20);
        #1 chk("fl_stall_in", 32'(stall), 32'd1);
        tick();
        chk("fl_valid", 32'(valid), 32'd0);
        chk("fl_opcode_rs", 32'({opcode, rs}), 32'd0);
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_pc", 32'(PCnext_out), 32'd16);

        // Asynchronous reset mid-cycle with live state
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hCAFEF00D, 32'h00631800, 6'd24);
        tick();
        drive(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 32'h00631800, 6'd28);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", 32'(valid), 32'd0);
        chk("ar_rs_data", rs_data, 32'd0);
        chk("ar_pc", 32'(PCnext_out), 32'd0);
        compare_all();
        #2 rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'h00631800, 6'd28);
        tick();
        chk("ar_after_rs", rs_data, 32'd0);
        chk("ar_after_rt", rt_data, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ins = $urandom();
            if ($urandom_range(0, 1) == 0) begin
                ins[25:21] = 5'($urandom_range(0, 7));
                ins[20:16] = 5'($urandom_range(0, 7));
            end
            case ($urandom_range(0, 2))
                0: ert = m_ir[25:21];
                1: ert = m_ir[20:16];
                default: ert = 5'($urandom_range(0, 31));
            endcase
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, ert,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
                  ins, PW'($urandom()));
            tick();
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1 compare_all();
                #1 rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 6, giving the PC/address width in bits.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock, rising-edge active.
REQ-003 The port rst SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-low reset.
REQ-004 The port PCnext_in SHALL be an input, PC_WIDTH bits wide, carrying PC+4 from the fetch stage.
REQ-005 The port Instruction_in SHALL be an input, 32 bits wide, carrying the fetched instruction.
REQ-006 The port flush SHALL be an input, 1 bit wide, indicating that a taken branch squashes the fetched instruction.
REQ-007 The port ex_MemRead SHALL be an input, 1 bit wide, indicating that the EX-stage instruction is a load.
REQ-008 The port ex_rt SHALL be an input, 5 bits wide, carrying the destination register of the EX-stage load.
REQ-009 The port wb_RegWrite SHALL be an input, 1 bit wide, enabling the write-back register write.
REQ-010 The port wb_rd SHALL be an input, 5 bits wide, carrying the write-back destination register.
REQ-011 The port wb_data SHALL be an input, 32 bits wide, carrying the write-back data.
REQ-012 The port PCnext_out SHALL be an output, PC_WIDTH bits wide, carrying the latched PC+4.
REQ-013 The port valid SHALL be an output, 1 bit wide, set while the latched instruction is real and not a bubble.
REQ-014 The port opcode SHALL be an output, 6 bits wide; the port funct SHALL be an output, 6 bits wide.
REQ-015 The ports rs, rt and rd SHALL be outputs, each 5 bits wide, carrying the register fields.
REQ-016 The port imm_ext SHALL be an output, 32 bits wide, carrying the sign-extended immediate.
REQ-017 The ports rs_data and rt_data SHALL be outputs, each 32 bits wide, carrying the register operands.
REQ-018 The port stall SHALL be an output, 1 bit wide; when asserted, upstream SHALL hold the PC and downstream SHALL insert a bubble.

Function
REQ-019 The IF/ID latch SHALL hold PCnext_out, the instruction register ir and valid.
REQ-020 The IF/ID latch SHALL update on each rising clk edge with the following priority: flush, then stall, then load.
REQ-021 When flush=1, the latch SHALL set ir to 0 (NOP) and valid to 0, and SHALL leave PCnext_out unchanged; flush SHALL override stall.
REQ-022 When flush=0 and stall=1, the latch SHALL hold all of its contents.
REQ-023 Otherwise, the latch SHALL set ir to Instruction_in, PCnext_out to PCnext_in and valid to 1.
REQ-024 The decode outputs SHALL be combinational from ir: opcode=ir[31:26], rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], funct=ir[5:0].
REQ-025 The output imm_ext SHALL be ir[15] replicated 16 times concatenated with ir[15:0].
REQ-026 The register file SHALL be 32 entries of 32 bits, written on the rising clk edge when wb_RegWrite=1 and wb_rd!=0.
REQ-027 Register 0 SHALL always read as 0, and writes to register 0 SHALL be ignored.
REQ-028 Register reads SHALL be combinational and SHALL have zero cycles of latency from ir.
REQ-029 Write-through bypass: if wb_RegWrite=1, wb_rd!=0 and wb_rd equals rs, rs_data SHALL equal wb_data in the same cycle; rt_data SHALL behave identically for rt.
REQ-030 The output stall SHALL be combinational: valid & ex_MemRead & (ex_rt!=0) & (ex_rt==rs | ex_rt==rt).
REQ-031 A load-use stall SHALL last exactly one cycle, because the load leaves EX on the next edge; the block SHALL keep no stall state.
REQ-032 When stall and flush are asserted in the same cycle, the flush SHALL win and valid=0 on the next cycle, which deasserts stall.
REQ-033 The fields of a bubble SHALL decode as all zero, so stall=0 whenever valid=0.

Reset
REQ-034 When rst=0, the block SHALL clear ir, PCnext_out and valid to 0 and clear all 32 registers to 0 immediately, without waiting for clk.
REQ-035 While in reset, all decode outputs, imm_ext, rs_data, rt_data and stall SHALL read 0.
REQ-036 On the first rising edge after rst returns to 1, the block SHALL load normally per REQ-020 to REQ-023.
REQ-037 Asserting reset mid-stall or mid-flush SHALL abort the operation, with no residual state.

Verification
REQ-038 Reset release then Instruction_in=0x2008FFFC, PCnext_in=4 -> after one edge: opcode=0x08, rs=0, rt=8, imm_ext=0xFFFFFFFC, PCnext_out=4, valid=1.
REQ-039 wb_RegWrite=1, wb_rd=9, wb_data=0x12345678 with ir rs=9 -> rs_data=0x12345678 in the same cycle (bypass) and on later cycles with the write disabled (stored).
REQ-040 wb_rd=0 with wb_data=0xFFFFFFFF written, then read of register 0 -> rs_data=0.
REQ-041 ir rs=5, ex_MemRead=1, ex_rt=5 -> stall=1, latch holds for exactly one edge; the next cycle with ex_MemRead=0 gives stall=0, then a new instruction loads.
REQ-042 flush=1 and stall=1 in the same cycle -> next cycle ir=0, valid=0, stall=0, PCnext_out unchanged.
REQ-043 rst driven low between clock edges with registers nonzero and valid=1 -> all outputs 0 immediately; after release, register reads return 0.
